mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised successor to the 8-bit free-running `counter`: a programmable up/down modulo counter with enable, synchronous load, wrap or saturate mode, and registered event flags. Used wherever the design needs a tick/index generator with a non-power-of-two terminal value. It is a drop-in replacement for `counter` when `enable=1`, `up=1`, `load=0`, `wrap_mode=1` and `MAX_VALUE=2**WIDTH-1`.

## Interface
- `WIDTH`, 8: counter width in bits; legal range 2..32.
- `MAX_VALUE`, 2**WIDTH-1: terminal count (inclusive upper bound); legal range 1..2**WIDTH-1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: count enable; when low, `value` holds.
- `up` input 1: direction; 1 counts up, 0 counts down.
- `load` input 1: synchronous load strobe.
- `load_value` input WIDTH: value to load.
- `wrap_mode` input 1: 1 selects wrap at the bounds, 0 selects saturate at the bounds.
- `clear_ovf` input 1: clears the sticky `overflow` flag.
- `value` output WIDTH: current count.
- `wrapped` output 1: one-cycle pulse, high in the cycle after a wrap occurred.
- `at_limit` output 1: high while `value` equals the bound in the current direction (`MAX_VALUE` when `up=1`, 0 when `up=0`); combinational from `value` and `up`.
- `overflow` output 1: sticky; set on any wrap or any blocked saturating step.

## Operation
- Reset values: `value=0`, `wrapped=0`, `overflow=0`.
- Priority per edge: `reset` > `load` > `enable` count > hold.
- Load: `value <= min(load_value, MAX_VALUE)`. Loading clamps silently and does not set `overflow` or `wrapped`.
- Count up, below `MAX_VALUE`: `value+1`.
- Count up, at `MAX_VALUE`: in wrap mode, `value <= 0`, `wrapped` pulses and `overflow` is set; in saturate mode, `value` holds and `overflow` is set.
- Count down, above 0: `value-1`.
- Count down, at 0: in wrap mode, `value <= MAX_VALUE`, `wrapped` pulses and `overflow` is set; in saturate mode, `value` holds and `overflow` is set.
- `up` and `wrap_mode` may change on any cycle. They take effect at the next edge with no pipeline.
- `overflow`: when `clear_ovf` and a new overflow event fall on the same edge, the set wins and `overflow` stays 1. Reset clears it.
- `wrapped` is 0 on any edge without a wrap, including load, hold, and reset edges.
- Next-state arithmetic uses WIDTH+1 bits internally. The result is never allowed to alias through 2**WIDTH when `MAX_VALUE<2**WIDTH-1`.

## Timing
- Latency is one cycle: controls sampled at edge N are reflected on `value`/`wrapped`/`overflow` after edge N.
- `at_limit` is valid in the same cycle as `value`.
- Reset mid-count: `value=0` after the reset edge regardless of `load`/`enable`. Counting resumes on the first edge with `reset=0`.
- Reset held for multiple cycles: outputs stay at their reset values.
- Load and enable together: the load wins and no step is applied in that cycle.

## Structure
- Package `counter_pkg`:
  - `typedef enum logic {DIR_DOWN, DIR_UP}`.
  - `typedef enum logic {MODE_SAT, MODE_WRAP}`.
  - Function `clamp(value, max)` shared with other counter blocks.
- One sub-module, `mod_counter_next`: combinational next-value/event calculator. Inputs are `value`, `up`, `wrap_mode` and `MAX_VALUE`; outputs are `next_value`, `wrap_evt` and `ovf_evt`.
- The top level holds only the registers and the priority mux.

## Test plan
- Reset and free-run: `WIDTH=8`, default `MAX_VALUE`, enable=1, up=1, wrap. Pulse reset at t=17 for 11 time units, then again at t=57 for 5 time units. Required: `value=0` after each reset edge, increments by 1 per cycle, 255→0 with one `wrapped` pulse and `overflow=1`.
- Modulo wrap down: `MAX_VALUE=9`, load 3, count down. Required sequence 3,2,1,0,9,8; `wrapped` high exactly in the cycle `value=9`; `at_limit` high while `value=0`.
- Saturate: `MAX_VALUE=9`, wrap_mode=0, load 8, count up 3 cycles. Required: 9,9,9; `overflow=1` from the cycle after the first blocked step; `wrapped` never asserts.
- Load clamp and priority: with `MAX_VALUE=9`, apply `load_value=200` with enable=1. Required: `value=9`, no `overflow`. Then assert `reset` and `load` together. Required: `value=0`.
- Hold and clear: with enable=0 for 5 cycles, `value` is constant. Assert `clear_ovf` on the same edge as a wrap. Required: `overflow` stays 1. Assert `clear_ovf` alone on the next edge. Required: `overflow=0`.
- Direction flip at a bound: `value=0`, up=0 then up=1 on the next edge (wrap mode). Required: 0→9→0 with two `wrapped` pulses.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================================
// Module  : counter_pkg
// Brief   : Shared types and helpers for the counter family.
// Revision: 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {MODE_SAT = 1'b0, MODE_WRAP = 1'b1} mode_e;

  // Widest counter supported; helpers work on one extra bit of headroom.
  localparam int CNT_MAX_WIDTH = 32;

  function automatic logic [CNT_MAX_WIDTH:0] clamp(
    input logic [CNT_MAX_WIDTH:0] value,
    input logic [CNT_MAX_WIDTH:0] max
  );
    return (value > max) ? max : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_next.sv
// ============================================================================
// Module  : mod_counter_next
// Brief   : Combinational next-value and bound-event calculator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_counter_next
  import counter_pkg::*;
#(
  parameter int                       WIDTH     = 8,
  parameter logic [CNT_MAX_WIDTH:0]   MAX_VALUE = (33'd1 << WIDTH) - 33'd1
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             wrap_mode,
  output logic [WIDTH-1:0] next_value,
  output logic             wrap_evt,
  output logic             ovf_evt
);

  localparam logic [WIDTH:0] MAX_EXT = MAX_VALUE[WIDTH:0];
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  dir_e           dir;
  mode_e          mode;
  logic [WIDTH:0] value_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;

  assign dir       = dir_e'(up);
  assign mode      = mode_e'(wrap_mode);
  assign value_ext = {1'b0, value};
  // The extra bit keeps the step from aliasing past 2**WIDTH or below zero.
  assign inc_ext   = value_ext + ONE_EXT;
  assign dec_ext   = value_ext - ONE_EXT;

  always_comb begin
    next_value = value;
    wrap_evt   = 1'b0;
    ovf_evt    = 1'b0;
    if (dir == DIR_UP) begin
      if (inc_ext > MAX_EXT) begin
        ovf_evt = 1'b1;
        if (mode == MODE_WRAP) begin
          next_value = '0;
          wrap_evt   = 1'b1;
        end
      end else begin
        next_value = inc_ext[WIDTH-1:0];
      end
    end else begin
      if (dec_ext[WIDTH]) begin
        ovf_evt = 1'b1;
        if (mode == MODE_WRAP) begin
          next_value = MAX_EXT[WIDTH-1:0];
          wrap_evt   = 1'b1;
        end
      end else begin
        next_value = dec_ext[WIDTH-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module  : mod_counter
// Brief   : Programmable up/down modulo counter with wrap/saturate and flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_counter
  import counter_pkg::*;
#(
  parameter int                       WIDTH     = 8,
  parameter logic [CNT_MAX_WIDTH:0]   MAX_VALUE = (33'd1 << WIDTH) - 33'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             wrap_mode,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] value,
  output logic             wrapped,
  output logic             at_limit,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_W = MAX_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] next_value;
  logic             wrap_evt;
  logic             ovf_evt;
  logic [WIDTH-1:0] load_clamped;
  logic             step;

  mod_counter_next #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE)
  ) u_next (
    .value      (value),
    .up         (up),
    .wrap_mode  (wrap_mode),
    .next_value (next_value),
    .wrap_evt   (wrap_evt),
    .ovf_evt    (ovf_evt)
  );

  assign load_clamped = WIDTH'(clamp((CNT_MAX_WIDTH+1)'(load_value), MAX_VALUE));
  assign step         = enable && !load;
  assign at_limit     = up ? (value == MAX_W) : (value == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      value    <= '0;
      wrapped  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        value <= load_clamped;
      end else if (enable) begin
        value <= next_value;
      end
      wrapped  <= step && wrap_evt;
      // A new event beats a simultaneous clear.
      overflow <= (step && ovf_evt) || (overflow && !clear_ovf);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module  : tb_mod_counter
// Brief   : Self-checking bench: full-range and modulo-10 counters, shared stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mod_counter;

  logic       clk;
  logic       reset, enable, up, load, wrap_mode, clear_ovf;
  logic [7:0] load_value;

  logic [7:0] f_value, m_value;
  logic       f_wrapped, f_at_limit, f_overflow;
  logic       m_wrapped, m_at_limit, m_overflow;

  int n_cmp = 0;
  int n_err = 0;

  mod_counter #(.WIDTH(8)) dut_full (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .wrap_mode(wrap_mode), .clear_ovf(clear_ovf),
    .value(f_value), .wrapped(f_wrapped), .at_limit(f_at_limit), .overflow(f_overflow)
  );

  mod_counter #(.WIDTH(8), .MAX_VALUE(33'd9)) dut_mod (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .wrap_mode(wrap_mode), .clear_ovf(clear_ovf),
    .value(m_value), .wrapped(m_wrapped), .at_limit(m_at_limit), .overflow(m_overflow)
  );

  // Rising edges at 10, 20, 30, ...
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1; #5;
      clk = 1'b0; #5;
    end
  end

  // Reference model: index 0 = full-range counter, 1 = modulo-10 counter.
  int maxv [2] = '{255, 9};
  int mv   [2] = '{0, 0};
  int mw   [2] = '{0, 0};
  int mo   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mv[k] = 0; mw[k] = 0; mo[k] = 0;
      end else if (load) begin
        mv[k] = (int'(load_value) > maxv[k]) ? maxv[k] : int'(load_value);
        mw[k] = 0;
        if (clear_ovf) mo[k] = 0;
      end else if (enable) begin
        automatic int hit = 0;
        mw[k] = 0;
        if (up) begin
          if (mv[k] == maxv[k]) begin
            hit = 1;
            if (wrap_mode) begin mv[k] = 0; mw[k] = 1; end
          end else mv[k] = mv[k] + 1;
        end else begin
          if (mv[k] == 0) begin
            hit = 1;
            if (wrap_mode) begin mv[k] = maxv[k]; mw[k] = 1; end
          end else mv[k] = mv[k] - 1;
        end
        if (hit == 1) mo[k] = 1;
        else if (clear_ovf) mo[k] = 0;
      end else begin
        mw[k] = 0;
        if (clear_ovf) mo[k] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0;
    wrap_mode = 1'b1; clear_ovf = 1'b0; load_value = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; up = 1'b1; load = 1'b0;
    wrap_mode = 1'b1; clear_ovf = 1'b0; load_value = 8'd0;
    #11;
    n_cmp++;
    if ({f_value, f_wrapped, f_overflow, m_value, m_wrapped, m_overflow} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_state: got f=%0d/%0b/%0b m=%0d/%0b/%0b want all 0",
               f_value, f_wrapped, f_overflow, m_value, m_wrapped, m_overflow);
    end
  endtask

  task automatic test_free_run();
    int pulses = 0;
    #1  reset = 1'b0;          // t=12
    #5  reset = 1'b1;          // t=17
    #11 reset = 1'b0;          // t=28
    #23;                       // t=51, after edges 30,40,50
    n_cmp++;
    if (f_value !== 8'd3) begin
      n_err++;
      $display("FAIL count_after_reset: got %0d want 3", f_value);
    end
    #6  reset = 1'b1;          // t=57
    #4;                        // t=61, after reset edge at 60
    n_cmp++;
    if (f_value !== 8'd0 || f_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL second_reset: got %0d/%0b want 0/0", f_value, f_overflow);
    end
    #1  reset = 1'b0;          // t=62
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (f_wrapped) pulses++;
      n_cmp++;
      if (f_value !== 8'(i % 256) || f_wrapped !== (i == 256) ||
          f_overflow !== (i >= 256) || m_value !== 8'(mv[1]) ||
          m_wrapped !== 1'(mw[1]) || m_overflow !== 1'(mo[1])) begin
        n_err++;
        $display("FAIL free_run[%0d]: got f=%0d/%0b/%0b m=%0d/%0b/%0b want f=%0d/%0b/%0b m=%0d/%0d/%0d",
                 i, f_value, f_wrapped, f_overflow, m_value, m_wrapped, m_overflow,
                 i % 256, i == 256, i >= 256, mv[1], mw[1], mo[1]);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL wrap_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_mod_wrap_down();
    int seq [6] = '{3, 2, 1, 0, 9, 8};
    idle_inputs();
    load = 1'b1; load_value = 8'd3; enable = 1'b1; up = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      n_cmp++;
      if (m_value !== 8'(seq[i]) || m_wrapped !== (seq[i] == 9) ||
          m_at_limit !== (seq[i] == 0)) begin
        n_err++;
        $display("FAIL wrap_down[%0d]: got %0d/w%0b/l%0b want %0d/w%0b/l%0b",
                 i, m_value, m_wrapped, m_at_limit, seq[i], seq[i] == 9, seq[i] == 0);
      end
    end
  endtask

  task automatic test_saturate();
    idle_inputs();
    wrap_mode = 1'b0; load = 1'b1; load_value = 8'd8; clear_ovf = 1'b1;
    tick();
    load = 1'b0; clear_ovf = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (m_value !== 8'd9 || m_wrapped !== 1'b0 || m_overflow !== (i >= 1) ||
          m_at_limit !== 1'b1) begin
        n_err++;
        $display("FAIL saturate[%0d]: got %0d/w%0b/o%0b/l%0b want 9/w0/o%0b/l1",
                 i, m_value, m_wrapped, m_overflow, m_at_limit, i >= 1);
      end
    end
  endtask

  task automatic test_load_clamp();
    idle_inputs();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0; load = 1'b1; load_value = 8'd200; enable = 1'b1;
    tick();
    n_cmp++;
    if (m_value !== 8'd9 || m_overflow !== 1'b0 || m_wrapped !== 1'b0 ||
        f_value !== 8'd200 || f_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL load_clamp: got m=%0d/o%0b/w%0b f=%0d/o%0b want m=9/o0/w0 f=200/o0",
               m_value, m_overflow, m_wrapped, f_value, f_overflow);
    end
    reset = 1'b1; load_value = 8'd5;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (m_value !== 8'd0 || f_value !== 8'd0) begin
      n_err++;
      $display("FAIL reset_over_load: got m=%0d f=%0d want 0/0", m_value, f_value);
    end
  endtask

  task automatic test_hold_clear();
    idle_inputs();
    load = 1'b1; load_value = 8'd5;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = 1'($urandom); wrap_mode = 1'($urandom);
      tick();
      n_cmp++;
      if (m_value !== 8'd5 || f_value !== 8'd5 || m_wrapped !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: got m=%0d f=%0d w%0b want 5/5/w0", i, m_value, f_value, m_wrapped);
      end
    end
    up = 1'b1; wrap_mode = 1'b1; load = 1'b1; load_value = 8'd9;
    tick();
    load = 1'b0; enable = 1'b1; clear_ovf = 1'b1;
    tick();
    n_cmp++;
    if (m_value !== 8'd0 || m_wrapped !== 1'b1 || m_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clear_vs_wrap: got %0d/w%0b/o%0b want 0/w1/o1", m_value, m_wrapped, m_overflow);
    end
    enable = 1'b0;
    tick();
    clear_ovf = 1'b0;
    n_cmp++;
    if (m_overflow !== 1'b0 || m_wrapped !== 1'b0 || m_value !== 8'd0) begin
      n_err++;
      $display("FAIL clear_alone: got o%0b/w%0b/%0d want o0/w0/0", m_overflow, m_wrapped, m_value);
    end
  endtask

  task automatic test_dir_flip();
    idle_inputs();
    load = 1'b1; load_value = 8'd0;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b0;
    tick();
    n_cmp++;
    if (m_value !== 8'd9 || m_wrapped !== 1'b1 || m_at_limit !== 1'b0) begin
      n_err++;
      $display("FAIL flip_down: got %0d/w%0b/l%0b want 9/w1/l0", m_value, m_wrapped, m_at_limit);
    end
    up = 1'b1;
    tick();
    n_cmp++;
    if (m_value !== 8'd0 || m_wrapped !== 1'b1 || m_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL flip_up: got %0d/w%0b/o%0b want 0/w1/o1", m_value, m_wrapped, m_overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      load       = ($urandom_range(0, 7) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      up         = 1'($urandom);
      wrap_mode  = 1'($urandom);
      clear_ovf  = ($urandom_range(0, 7) == 0);
      load_value = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      tick();
      n_cmp++;
      if (f_value !== 8'(mv[0]) || f_wrapped !== 1'(mw[0]) || f_overflow !== 1'(mo[0]) ||
          f_at_limit !== (up ? (mv[0] == 255) : (mv[0] == 0)) ||
          m_value !== 8'(mv[1]) || m_wrapped !== 1'(mw[1]) || m_overflow !== 1'(mo[1]) ||
          m_at_limit !== (up ? (mv[1] == 9) : (mv[1] == 0))) begin
        n_err++;
        $display("FAIL random[%0d]: got f=%0d/%0b/%0b/%0b m=%0d/%0b/%0b/%0b want f=%0d/%0d/%0d m=%0d/%0d/%0d up=%0b",
                 i, f_value, f_wrapped, f_overflow, f_at_limit,
                 m_value, m_wrapped, m_overflow, m_at_limit,
                 mv[0], mw[0], mo[0], mv[1], mw[1], mo[1], up);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mod_wrap_down();
    test_saturate();
    test_load_clamp();
    test_hold_clear();
    test_dir_flip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
